// File: rtl/key_pulse_gen.sv
// key_pulse_gen: synchronises, debounces and strobes three front-panel keys (left, right, mode).
// Define KEY_REPEAT_EN to build hold-to-auto-repeat on the left/right keys.
module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int NUM_MODES       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_l_raw,
  input  logic       key_r_raw,
  input  logic       key_m_raw,
  output logic       L_pulse,
  output logic       R_pulse,
  output logic [2:0] current_mode
);

  localparam int NK    = 3;
  localparam int KEY_L = 0;
  localparam int KEY_R = 1;
  localparam int KEY_M = 2;

  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(REPEAT_PERIOD - 1);
`endif
  localparam logic [2:0]       MODE_LAST = 3'(NUM_MODES - 1);
  localparam logic             REL_LEVEL = KEY_ACTIVE_LOW;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_REL
`ifdef KEY_REPEAT_EN
    , REPEAT
`endif
  } key_state_e;

  logic [NK-1:0] raw_keys;
  logic [NK-1:0] sync1;
  logic [NK-1:0] sync2;
  logic [NK-1:0] key_s;
  logic [NK-1:0] evt;

  key_state_e       state_q [NK];
  key_state_e       state_d [NK];
  logic [CNT_W-1:0] cnt_q   [NK];
  logic [CNT_W-1:0] cnt_d   [NK];

  assign raw_keys = {key_m_raw, key_r_raw, key_l_raw};

  // Synchronisers clear to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1 <= {NK{REL_LEVEL}};
      sync2 <= {NK{REL_LEVEL}};
    end else begin
      sync1 <= raw_keys;
      sync2 <= sync1;
    end
  end

  assign key_s = KEY_ACTIVE_LOW ? ~sync2 : sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NK; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    evt     = '0;
    for (int k = 0; k < NK; k++) begin
      case (state_q[k])
        IDLE: begin
          if (key_s[k]) begin
            state_d[k] = DB_PRESS;
            cnt_d[k]   = '0;
          end
        end
        DB_PRESS: begin
          if (!key_s[k]) begin
            state_d[k] = IDLE;
          end else if (cnt_q[k] == DB_LAST) begin
            evt[k]     = 1'b1;
            state_d[k] = HELD;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!key_s[k]) begin
            state_d[k] = DB_REL;
            cnt_d[k]   = '0;
          end
`ifdef KEY_REPEAT_EN
          else if (k != KEY_M) begin
            if (cnt_q[k] == RD_LAST) begin
              evt[k]     = 1'b1;
              state_d[k] = REPEAT;
              cnt_d[k]   = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (!key_s[k]) begin
            state_d[k] = DB_REL;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == RP_LAST) begin
            evt[k]   = 1'b1;
            cnt_d[k] = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
`endif
        end
        DB_REL: begin
          // A bounce back to pressed restarts the release count without raising anything.
          if (key_s[k]) begin
            cnt_d[k] = '0;
          end else if (cnt_q[k] == DB_LAST) begin
            state_d[k] = IDLE;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        default: begin
          state_d[k] = IDLE;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  // Coincident left/right events cancel so the adjuster never sees both strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      L_pulse      <= 1'b0;
      R_pulse      <= 1'b0;
      current_mode <= '0;
    end else begin
      L_pulse <= evt[KEY_L] & ~evt[KEY_R];
      R_pulse <= evt[KEY_R] & ~evt[KEY_L];
      if (evt[KEY_M]) begin
        current_mode <= (current_mode == MODE_LAST) ? 3'd0 : current_mode + 3'd1;
      end
    end
  end

endmodule
